// File: rtl/cdc_handshake_sender.sv
// Source-domain end of a 4-phase req/ack CDC handshake carrying a WIDTH-bit word.
// Ports:
//   clk       source-domain clock
//   reset     synchronous, active-high reset
//   in_valid  local word available
//   in_ready  block can accept a word this cycle (registered, high only in IDLE)
//   in_data   local word, sampled when in_valid && in_ready
//   data_out  registered word presented to the destination domain
//   req_out   registered request level to the destination domain
//   ack_in    asynchronous acknowledge from the destination domain
//   busy      high whenever the handshake engine is not IDLE
module cdc_handshake_sender #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned EXTRA_DEPTH = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] data_out,
   output logic             req_out,
   input  logic             ack_in,
   output logic             busy
);

   localparam int unsigned DEPTH = 2 + EXTRA_DEPTH;

   localparam logic [1:0] ST_DRAIN   = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_WAIT_HI = 2'd2;
   localparam logic [1:0] ST_WAIT_LO = 2'd3;

   logic [DEPTH-1:0] ack_chain;
   logic             ack_sync;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic             req_nxt;
   logic             ready_nxt;
   logic             busy_nxt;

   // ack synchronizer; resets to all ones so a stale ack is never read as idle
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_chain <= '1;
      end else begin
         ack_chain <= {ack_chain[DEPTH-2:0], ack_in};
      end
   end

   assign ack_sync = ack_chain[DEPTH-1];

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_DRAIN;
         req_out  <= 1'b0;
         data_out <= WIDTH'(0);
         in_ready <= 1'b0;
         busy     <= 1'b1;
      end else begin
         state    <= state_nxt;
         req_out  <= req_nxt;
         data_out <= data_nxt;
         in_ready <= ready_nxt;
         busy     <= busy_nxt;
      end
   end

   // Next-state and next-output decode; outputs are functions of the next state
   // so every output port comes straight from a flop.
   always_comb begin
      state_nxt = state;
      data_nxt  = data_out;
      case (state)
         ST_DRAIN: begin
            if (!ack_sync) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            // in_ready is already high in IDLE; it is the registered copy of that fact
            if (in_valid && in_ready) begin
               data_nxt  = in_data;
               state_nxt = ST_WAIT_HI;
            end
         end
         ST_WAIT_HI: begin
            if (ack_sync) state_nxt = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (!ack_sync) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_DRAIN;
         end
      endcase
      req_nxt   = (state_nxt == ST_WAIT_HI);
      ready_nxt = (state_nxt == ST_IDLE);
      busy_nxt  = (state_nxt != ST_IDLE);
   end

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Bench for cdc_handshake_sender: scoreboard of accepted words plus directed latency checks.
module tb_cdc_handshake_sender;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT 1: EXTRA_DEPTH = 0 (DEPTH = 2)
   logic       reset1;
   logic       in_valid1;
   logic       in_ready1;
   logic [7:0] in_data1;
   logic [7:0] data_out1;
   logic       req_out1;
   logic       ack1;
   logic       busy1;
   logic       ack_man1;
   bit         instant;

   // DUT 2: EXTRA_DEPTH = 2 (DEPTH = 4)
   logic       reset2;
   logic       in_valid2;
   logic       in_ready2;
   logic [7:0] in_data2;
   logic [7:0] data_out2;
   logic       req_out2;
   logic       ack2;
   logic       busy2;

   assign ack1 = instant ? req_out1 : ack_man1;

   cdc_handshake_sender #(.WIDTH(8), .EXTRA_DEPTH(0)) dut1 (
      .clk      (clk),
      .reset    (reset1),
      .in_valid (in_valid1),
      .in_ready (in_ready1),
      .in_data  (in_data1),
      .data_out (data_out1),
      .req_out  (req_out1),
      .ack_in   (ack1),
      .busy     (busy1)
   );

   cdc_handshake_sender #(.WIDTH(8), .EXTRA_DEPTH(2)) dut2 (
      .clk      (clk),
      .reset    (reset2),
      .in_valid (in_valid2),
      .in_ready (in_ready2),
      .in_data  (in_data2),
      .data_out (data_out2),
      .req_out  (req_out2),
      .ack_in   (ack2),
      .busy     (busy2)
   );

   int         tests = 0;
   int         fails = 0;
   logic [7:0] sb[$];
   logic [7:0] cur_exp = 8'h00;
   bit         gap_chk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return req_out1 == 1'b0;
         1:       return in_ready1 == 1'b1;
         2:       return req_out2 == 1'b0;
         default: return in_ready2 == 1'b1;
      endcase
   endfunction

   // Count edges until a condition holds (bounded)
   task automatic measure(input int which, output int n);
      n = 0;
      forever begin
         tick;
         n++;
         if (cond(which) || n >= 100) break;
      end
   endtask

   task automatic wait_ready1;
      int n;
      n = 0;
      while (!in_ready1 && n < 100) begin
         tick;
         n++;
      end
      check("wait_ready1_timeout", 32'(in_ready1), 32'd1);
   endtask

   // Monitor: pops the scoreboard on every accept and checks data_out is held
   initial begin
      int   mcyc;
      int   last;
      bit   have_last;
      logic rst_s;
      logic acc;
      mcyc = 0;
      last = 0;
      have_last = 1'b0;
      forever begin
         @(posedge clk);
         rst_s = reset1;
         acc   = in_valid1 && in_ready1 && !reset1;
         mcyc++;
         @(negedge clk);
         if (rst_s) begin
            cur_exp   = 8'h00;
            have_last = 1'b0;
         end else if (acc) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_accept: data_out %0h accepted with empty scoreboard at %0t",
                        data_out1, $time);
            end else begin
               cur_exp = sb.pop_front();
               check("accept_data", 32'(data_out1), 32'(cur_exp));
               check("accept_req", 32'(req_out1), 32'd1);
            end
            if (gap_chk && have_last) check("accept_gap", 32'(mcyc - last), 32'd7);
            have_last = gap_chk;
            last      = mcyc;
         end
         check("data_hold", 32'(data_out1), 32'(cur_exp));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset1 = 1'b1; in_valid1 = 1'b0; in_data1 = 8'h00; ack_man1 = 1'b0; instant = 1'b0;
      reset2 = 1'b1; in_valid2 = 1'b0; in_data2 = 8'h00; ack2 = 1'b0;

      // Reset held several cycles: outputs sit at reset values
      repeat (3) begin
         tick;
         check("rst_req", 32'(req_out1), 32'd0);
         check("rst_ready", 32'(in_ready1), 32'd0);
         check("rst_busy", 32'(busy1), 32'd1);
         check("rst_data", 32'(data_out1), 32'd0);
         check("rst_req2", 32'(req_out2), 32'd0);
         check("rst_busy2", 32'(busy2), 32'd1);
      end
      reset1 = 1'b0;
      reset2 = 1'b0;

      // Reset release with ack low: in_ready low for 2 cycles then high
      tick;
      check("drain_c1_ready", 32'(in_ready1), 32'd0);
      check("drain_c1_req", 32'(req_out1), 32'd0);
      tick;
      check("drain_c2_ready", 32'(in_ready1), 32'd0);
      tick;
      check("drain_c3_ready", 32'(in_ready1), 32'd1);
      check("drain_c3_busy", 32'(busy1), 32'd0);
      check("drain_c3_req", 32'(req_out1), 32'd0);

      // Single transfer 0xA5
      in_valid1 = 1'b1; in_data1 = 8'hA5; sb.push_back(8'hA5);
      tick;
      in_valid1 = 1'b0; in_data1 = 8'h3C;
      check("single_req", 32'(req_out1), 32'd1);
      check("single_data", 32'(data_out1), 32'hA5);
      check("single_ready", 32'(in_ready1), 32'd0);
      tick;
      ack_man1 = 1'b1;
      measure(0, n);
      check("single_req_fall_lat", 32'(n), 32'd3);
      tick;
      ack_man1 = 1'b0;
      measure(1, n);
      check("single_ready_lat", 32'(n), 32'd3);

      // Back-to-back with an instant responder; busy-time in_data is garbage
      instant = 1'b1;
      gap_chk = 1'b1;
      for (int w = 1; w <= 3; w++) begin
         wait_ready1;
         in_valid1 = 1'b1;
         in_data1  = 8'(w);
         sb.push_back(8'(w));
         tick;
         in_data1 = 8'hE0 | 8'(w);
      end
      in_valid1 = 1'b0;
      wait_ready1;
      gap_chk = 1'b0;
      instant = 1'b0;
      check("b2b_drained", 32'(sb.size()), 32'd0);

      // Stalled responder: 50 cycles with ack low and in_valid toggling
      in_valid1 = 1'b1; in_data1 = 8'h5A; sb.push_back(8'h5A);
      tick;
      for (int i = 0; i < 50; i++) begin
         in_valid1 = ~in_valid1;
         in_data1  = 8'(i);
         tick;
         check("stall_req", 32'(req_out1), 32'd1);
         check("stall_ready", 32'(in_ready1), 32'd0);
      end
      in_valid1 = 1'b0;
      ack_man1 = 1'b1;
      measure(0, n);
      check("stall_req_fall_lat", 32'(n), 32'd3);
      ack_man1 = 1'b0;
      measure(1, n);
      check("stall_ready_lat", 32'(n), 32'd3);

      // Reset mid-handshake while in WAIT_HI with ack high
      in_valid1 = 1'b1; in_data1 = 8'hC3; sb.push_back(8'hC3);
      tick;
      in_valid1 = 1'b0;
      tick;
      ack_man1 = 1'b1;
      check("midrst_pre_req", 32'(req_out1), 32'd1);
      reset1 = 1'b1;
      tick;
      reset1 = 1'b0;
      check("midrst_req", 32'(req_out1), 32'd0);
      check("midrst_data", 32'(data_out1), 32'd0);
      check("midrst_busy", 32'(busy1), 32'd1);
      in_valid1 = 1'b1; in_data1 = 8'h99;
      repeat (10) begin
         tick;
         check("midrst_no_accept", 32'(in_ready1), 32'd0);
      end
      in_valid1 = 1'b0;
      ack_man1 = 1'b0;
      measure(1, n);
      check("midrst_ready_lat", 32'(n), 32'd3);

      // EXTRA_DEPTH=2 single transfer
      in_valid2 = 1'b1; in_data2 = 8'hA5;
      tick;
      in_valid2 = 1'b0; in_data2 = 8'h11;
      check("deep_req", 32'(req_out2), 32'd1);
      check("deep_data", 32'(data_out2), 32'hA5);
      tick;
      ack2 = 1'b1;
      measure(2, n);
      check("deep_req_fall_lat", 32'(n), 32'd5);
      check("deep_data_held", 32'(data_out2), 32'hA5);
      tick;
      ack2 = 1'b0;
      measure(3, n);
      check("deep_ready_lat", 32'(n), 32'd5);
      check("deep_data_final", 32'(data_out2), 32'hA5);

      tick;
      tick;
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
